// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 unsigned shift-add multiplier that borrows a shared ALU.
// One add-and-shift step is taken for every cycle the ALU is granted. Sixteen
// steps produce the 32-bit product in {hi, lo}.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod_hi,
    output logic [15:0] prod_lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic [3:0]  alu_Op,
    output logic        alu_Cin,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    input  logic [15:0] alu_Out,
    input  logic        alu_Cout
);

    localparam logic [3:0] ALU_OP_ADD = 4'b0100;
    localparam logic [4:0] LAST_STEP  = 5'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Multiplicand, partial-product high half, multiplier / product low half.
    // The ALU carry-out drops straight into hi[15] on each shift, so the carry
    // never needs its own flop between steps.
    logic [15:0] m_q;
    logic [15:0] hi_q;
    logic [15:0] lo_q;
    logic [4:0]  step_cnt;

    logic        accept;
    logic        step;

    // Start is honoured only from IDLE; a step happens only on a granted RUN cycle.
    always_comb begin
        accept = (state == S_IDLE) && start;
        step   = (state == S_RUN) && alu_gnt;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and all control / ALU-operand outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_req   = 1'b0;
        alu_A     = 16'h0000;
        alu_B     = 16'h0000;
        alu_Op    = 4'b0000;
        alu_Cin   = 1'b0;
        alu_invA  = 1'b0;
        alu_invB  = 1'b0;
        alu_sign  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                busy    = 1'b1;
                alu_req = 1'b1;
                // Operands stay driven during stalls so the ALU sees a stable
                // request whenever the arbiter finally grants it.
                alu_A   = hi_q;
                alu_B   = lo_q[0] ? m_q : 16'h0000;
                alu_Op  = ALU_OP_ADD;
                if (alu_gnt && (step_cnt == LAST_STEP)) begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, add-and-shift on every granted step.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q      <= 16'h0000;
            hi_q     <= 16'h0000;
            lo_q     <= 16'h0000;
            step_cnt <= 5'd0;
        end else if (accept) begin
            m_q      <= mcand;
            hi_q     <= 16'h0000;
            lo_q     <= mplier;
            step_cnt <= 5'd0;
        end else if (step) begin
            // {carry, sum, lo} shifted right by one: the consumed multiplier
            // bit falls off lo[0] and the sum's LSB becomes the new lo[15].
            hi_q     <= {alu_Cout, alu_Out[15:1]};
            lo_q     <= {alu_Out[0], lo_q[15:1]};
            step_cnt <= step_cnt + 5'd1;
        end
    end

    // The product registers are visible directly; they hold after DONE
    // until the next accepted start clears hi and reloads lo.
    assign prod_hi = hi_q;
    assign prod_lo = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: table-driven bench with a scoreboard for alu_mul_seq.
// Provides a behavioural shared ALU, drives grant stalls, aborts via reset
// and checks product, latency, handshake and idle bus values.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [3:0]  alu_Op;
    logic        alu_Cin;
    logic        alu_invA;
    logic        alu_invB;
    logic        alu_sign;
    logic [15:0] alu_Out;
    logic        alu_Cout;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .busy     (busy),
        .done     (done),
        .prod_hi  (prod_hi),
        .prod_lo  (prod_lo),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_Op   (alu_Op),
        .alu_Cin  (alu_Cin),
        .alu_invA (alu_invA),
        .alu_invB (alu_invB),
        .alu_sign (alu_sign),
        .alu_Out  (alu_Out),
        .alu_Cout (alu_Cout)
    );

    // Shared ALU model: only the add opcode produces a result.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = 17'd0;
        if (alu_Op == 4'b0100) begin
            alu_sum = {1'b0, (alu_invA ? ~alu_A : alu_A)}
                    + {1'b0, (alu_invB ? ~alu_B : alu_B)}
                    + {16'd0, alu_Cin};
        end
    end
    assign alu_Out  = alu_sum[15:0];
    assign alu_Cout = alu_sum[16];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          nstall;
        logic [31:0] prod;
    } vec_t;

    typedef struct {
        logic [31:0] prod;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_alu_idle(input string name);
        check({name, " alu A/B"}, {alu_A, alu_B}, 32'h0);
        check({name, " alu ctl"}, {23'd0, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign, alu_req}, 32'h0);
    endtask

    // One multiply: stalls grant on even RUN cycles k=2,4,... nstall times.
    // abort_at>0 pulses rst at that RUN cycle and expects no done afterwards.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int nstall,
                          input logic [31:0] exp_prod, input bit hold_start, input int abort_at);
        exp_t        e;
        exp_t        got;
        int          k;
        int          grants;
        int          stalls_left;
        int          dones;
        bit          stalled;
        logic [31:0] stall_prod;

        @(negedge clk);
        mcand   = a;
        mplier  = b;
        start   = 1'b1;
        alu_gnt = 1'b1;
        if (abort_at == 0) begin
            e.prod = exp_prod;
            e.lat  = 17 + nstall;
            sb_q.push_back(e);
        end

        @(negedge clk);
        if (!hold_start) start = 1'b0;
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
        check("busy after start", {31'd0, busy}, 32'd1);
        check("run alu ctl", {23'd0, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign, alu_req}, 32'h081);
        check("first alu A/B", {alu_A, alu_B}, {16'h0000, (b[0] ? a : 16'h0000)});

        k           = 1;
        grants      = 0;
        stalls_left = nstall;
        stalled     = 1'b0;
        stall_prod  = 32'h0;
        while (!done && k < 60) begin
            if (abort_at != 0 && k == abort_at) begin
                rst   = 1'b1;
                start = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                check("abort busy", {31'd0, busy}, 32'd0);
                check("abort done", {31'd0, done}, 32'd0);
                check("abort product", {prod_hi, prod_lo}, 32'h0);
                check_alu_idle("abort");
                dones = 0;
                repeat (25) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check("abort no done", 32'(dones), 32'd0);
                return;
            end
            if (stalls_left > 0 && k >= 2 && (k % 2) == 0) begin
                alu_gnt     = 1'b0;
                stalls_left--;
                stalled     = 1'b1;
                stall_prod  = {prod_hi, prod_lo};
            end else begin
                alu_gnt = 1'b1;
            end
            if (alu_req && alu_gnt) grants++;
            @(negedge clk);
            k++;
            if (stalled) begin
                check("stall hold", {prod_hi, prod_lo}, stall_prod);
                stalled = 1'b0;
            end
        end

        alu_gnt = 1'b1;
        start   = 1'b0;
        if (!done) begin
            check("done timeout", 32'd0, 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard empty at done", 32'd0, 32'd1);
            return;
        end
        got = sb_q.pop_front();
        check("product", {prod_hi, prod_lo}, got.prod);
        check("latency", 32'(k), 32'(got.lat));
        check("granted req cycles", 32'(grants), 32'd16);
        check("done cycle req/busy", {30'd0, alu_req, busy}, 32'd1);

        @(negedge clk);
        check("after done busy/done", {30'd0, busy, done}, 32'd0);
        check("product held", {prod_hi, prod_lo}, got.prod);
        check_alu_idle("idle");

        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("single done pulse", 32'(dones), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 0, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001};
        vecs[2] = '{16'h1234, 16'h0010, 3, 32'h0001_2340};
        vecs[3] = '{16'h0000, 16'hABCD, 0, 32'h0000_0000};
        vecs[4] = '{16'h9876, 16'h0000, 0, 32'h0000_0000};
        vecs[5] = '{16'h8000, 16'h8000, 1, 32'h4000_0000};
        vecs[6] = '{16'h00FF, 16'h0101, 2, 32'h0000_FFFF};
        vecs[7] = '{16'h0001, 16'hFFFF, 0, 32'h0000_FFFF};

        rst     = 1'b1;
        start   = 1'b0;
        mcand   = 16'h0;
        mplier  = 16'h0;
        alu_gnt = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy/done", {30'd0, busy, done}, 32'd0);
        check("reset product", {prod_hi, prod_lo}, 32'h0);
        check_alu_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].nstall, vecs[i].prod, 1'b0, 0);
        end

        // start held high through RUN and DONE
        run_op(16'h1234, 16'h5678, 0, 32'h0626_0060, 1'b1, 0);
        run_op(16'hA5A5, 16'h5A5A, 2, 32'(16'hA5A5) * 32'(16'h5A5A), 1'b1, 0);

        // reset in the middle of a run, then a fresh operation
        run_op(16'hBEEF, 16'h00AA, 0, 32'h0, 1'b0, 8);
        run_op(16'hBEEF, 16'h00AA, 0, 32'(16'hBEEF) * 32'(16'h00AA), 1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            int          rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = int'($urandom_range(0, 4));
            run_op(ra, rb, rs, 32'(ra) * 32'(rb), 1'b0, 0);
        end

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 mcand  input  16  multiplicand, unsigned.
REQ-006 mplier  input  16  multiplier, unsigned.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse, result valid.
REQ-009 prod_hi  output  16  product bits [31:16].
REQ-010 prod_lo  output  16  product bits [15:0].
REQ-011 alu_req  output  1  request for the shared ALU.
REQ-012 alu_gnt  input  1  ALU granted this cycle; ALU result usable same cycle.
REQ-013 alu_A, alu_B  output  16 each  ALU operands.
REQ-014 alu_Op  output  4  ALU opcode.
REQ-015 alu_Cin, alu_invA, alu_invB, alu_sign  output  1 each  ALU controls.
REQ-016 alu_Out  input  16  ALU result.
REQ-017 alu_Cout  input  1  ALU carry-out.

Function
REQ-018 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-019 IDLE: start=1 -> latch mcand into M, mplier into lo register, clear hi register and carry, clear step counter, go RUN; start=0 -> stay IDLE.
REQ-020 RUN: alu_req=1 every cycle; alu_A=hi, alu_B = M if lo[0]=1 else 16'h0000; alu_Op=4'b0100 (add); alu_Cin=0, alu_invA=0, alu_invB=0, alu_sign=0.
REQ-021 RUN step occurs only in a cycle with alu_gnt=1: {hi,lo} <= {alu_Cout, alu_Out, lo[15:1]} (33-bit value shifted right one), counter increments.
REQ-022 RUN with alu_gnt=0: all registers hold, no step, alu_* outputs remain driven per REQ-020.
REQ-023 After the 16th step (counter 15 -> 16) go DONE; counter 5 bits, no wrap.
REQ-024 DONE: done=1 for exactly that one cycle, alu_req=0, next state IDLE unconditionally.
REQ-025 Latency: start sampled at edge T with alu_gnt held 1 -> done high in cycle T+17; each grant-low RUN cycle adds one cycle.
REQ-026 prod_hi/prod_lo drive hi/lo registers; hold final product from DONE until the next accepted start (cleared/overwritten at that edge).
REQ-027 Outside RUN: alu_req=0 and alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign all 0.
REQ-028 start while busy=1 ignored; no restart, no queuing; start in DONE cycle also ignored.
REQ-029 Result equals mcand*mplier modulo 2^32 for all 16-bit inputs; ALU Ofl and Z not used.
REQ-030 mcand/mplier changes after acceptance have no effect on the operation in progress.

Reset
REQ-031 rst=1 at a rising edge: state IDLE, counter 0, M, hi, lo, carry 0; busy=0, done=0, prod_hi=prod_lo=0, alu_req=0 next cycle.
REQ-032 rst mid-RUN or in DONE aborts the operation; no done pulse is produced; rst dominates a simultaneous start.

Verification
REQ-033 mcand=3, mplier=5, alu_gnt=1 always, start at T -> done at T+17, prod_hi=16'h0000, prod_lo=16'h000F.
REQ-034 mcand=16'hFFFF, mplier=16'hFFFF -> prod_hi=16'hFFFE, prod_lo=16'h0001 (carry path exercised).
REQ-035 mcand=16'h1234, mplier=16'h0010, alu_gnt low on 3 RUN cycles -> done at T+20, product 32'h00012340, registers stable during stalls.
REQ-036 start re-asserted every cycle during RUN and DONE -> only one done per accepted start; result of first operation unaffected.
REQ-037 rst asserted at T+8 of a run -> next cycle busy=0, alu_req=0, products 0, no done; fresh start afterwards completes correctly.
REQ-038 mcand=0 or mplier=0 -> product 0, alu_req still asserted 16 granted cycles, done at T+17.
